// File: rtl/ddr_rw_wrr_arbiter_if.sv
// Request/grant bundle between the DDR read/write queues, the arbiter and the protocol layer.
// The master side drives requests and out_ready. The slave side (the arbiter) drives grants.
interface ddr_rw_wrr_arbiter_if #(
    parameter int unsigned PAYLOAD_W = 64
) ();
    logic                 rd_valid;
    logic                 rd_ready;
    logic [PAYLOAD_W-1:0] rd_payload;
    logic                 wr_valid;
    logic                 wr_ready;
    logic [PAYLOAD_W-1:0] wr_payload;
    logic [7:0]           wr_level;
    logic                 out_valid;
    logic                 out_ready;
    logic [PAYLOAD_W-1:0] out_payload;
    logic                 out_is_wr;
    logic [15:0]          rd_wrr_credit;
    logic [15:0]          wr_wrr_credit;
    logic                 mode_is_wr;
    logic                 turnaround_active;

    modport master (
        output rd_valid, rd_payload, wr_valid, wr_payload, wr_level, out_ready,
        input  rd_ready, wr_ready, out_valid, out_payload, out_is_wr,
               rd_wrr_credit, wr_wrr_credit, mode_is_wr, turnaround_active
    );

    modport slave (
        input  rd_valid, rd_payload, wr_valid, wr_payload, wr_level, out_ready,
        output rd_ready, wr_ready, out_valid, out_payload, out_is_wr,
               rd_wrr_credit, wr_wrr_credit, mode_is_wr, turnaround_active
    );
endinterface

// File: rtl/ddr_rw_wrr_arbiter.sv
// Weighted round-robin read/write arbiter with bus turnaround gaps and write-drain watermark.
// The selected request passes combinationally to the output. Mode, credits and turnaround are registered.
module ddr_rw_wrr_arbiter #(
    parameter int unsigned PAYLOAD_W  = 64,
    parameter int unsigned RD_WEIGHT  = 8,
    parameter int unsigned WR_WEIGHT  = 4,
    parameter int unsigned TURN_RD2WR = 4,
    parameter int unsigned TURN_WR2RD = 6,
    parameter int unsigned WR_HI_WM   = 24
) (
    input logic                 clk,
    input logic                 rst_n,
    ddr_rw_wrr_arbiter_if.slave bus
);
    localparam logic [15:0] RdWeight = 16'(RD_WEIGHT);
    localparam logic [15:0] WrWeight = 16'(WR_WEIGHT);
    localparam logic [15:0] TurnRd2Wr = 16'(TURN_RD2WR - 1);
    localparam logic [15:0] TurnWr2Rd = 16'(TURN_WR2RD - 1);

    typedef enum logic [1:0] {StRd = 2'd0, StWr = 2'd1, StTurn = 2'd2} state_e;

    state_e      r_state;
    logic        r_tgt;
    logic [15:0] r_turn_cnt;
    logic [15:0] r_rd_credit;
    logic [15:0] r_wr_credit;

    logic                 w_in_rd;
    logic                 w_in_wr;
    logic                 w_out_valid;
    logic                 w_hs;
    logic                 w_stall;
    logic                 w_wr_hi;
    logic [15:0]          w_rd_cnext;
    logic [15:0]          w_wr_cnext;
    logic [PAYLOAD_W-1:0] w_payload;

    // While reset is held the datapath behaves as RD, regardless of the current state.
    assign w_in_rd = !rst_n || (r_state == StRd);
    assign w_in_wr = rst_n && (r_state == StWr);

    assign w_out_valid = w_in_rd ? bus.rd_valid : (w_in_wr ? bus.wr_valid : 1'b0);
    assign w_payload   = w_in_wr ? bus.wr_payload : bus.rd_payload;
    assign w_hs        = w_out_valid && bus.out_ready;
    assign w_stall     = w_out_valid && !bus.out_ready;
    assign w_wr_hi     = 32'(bus.wr_level) >= WR_HI_WM;

    assign w_rd_cnext = (w_hs && (r_rd_credit != 16'd0)) ? r_rd_credit - 16'd1 : r_rd_credit;
    assign w_wr_cnext = (w_hs && (r_wr_credit != 16'd0)) ? r_wr_credit - 16'd1 : r_wr_credit;

    assign bus.out_valid         = w_out_valid;
    assign bus.out_payload       = w_payload;
    assign bus.out_is_wr         = w_in_wr;
    assign bus.rd_ready          = w_in_rd && bus.out_ready;
    assign bus.wr_ready          = w_in_wr && bus.out_ready;
    assign bus.rd_wrr_credit     = r_rd_credit;
    assign bus.wr_wrr_credit     = r_wr_credit;
    assign bus.mode_is_wr        = rst_n && ((r_state == StWr) || ((r_state == StTurn) && r_tgt));
    assign bus.turnaround_active = rst_n && (r_state == StTurn);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= StRd;
            r_tgt       <= 1'b0;
            r_turn_cnt  <= 16'd0;
            r_rd_credit <= RdWeight;
            r_wr_credit <= WrWeight;
        end else begin
            unique case (r_state)
                StRd: begin
                    // A presented but unaccepted command pins the state.
                    if (!w_stall) begin
                        if (bus.wr_valid && (!bus.rd_valid || (w_rd_cnext == 16'd0) || w_wr_hi)) begin
                            r_state     <= StTurn;
                            r_tgt       <= 1'b1;
                            r_turn_cnt  <= TurnRd2Wr;
                            r_rd_credit <= w_rd_cnext;
                        end else begin
                            r_rd_credit <= (w_rd_cnext == 16'd0) ? RdWeight : w_rd_cnext;
                        end
                    end
                end
                StWr: begin
                    if (!w_stall) begin
                        if (w_wr_hi) begin
                            r_wr_credit <= (w_wr_cnext == 16'd0) ? WrWeight : w_wr_cnext;
                        end else if (bus.rd_valid && (!bus.wr_valid || (w_wr_cnext == 16'd0))) begin
                            r_state     <= StTurn;
                            r_tgt       <= 1'b0;
                            r_turn_cnt  <= TurnWr2Rd;
                            r_wr_credit <= w_wr_cnext;
                        end else begin
                            r_wr_credit <= (w_wr_cnext == 16'd0) ? WrWeight : w_wr_cnext;
                        end
                    end
                end
                StTurn: begin
                    if (r_turn_cnt == 16'd0) begin
                        if (r_tgt) begin
                            r_state     <= StWr;
                            r_wr_credit <= WrWeight;
                        end else begin
                            r_state     <= StRd;
                            r_rd_credit <= RdWeight;
                        end
                    end else begin
                        r_turn_cnt <= r_turn_cnt - 16'd1;
                    end
                end
                default: r_state <= StRd;
            endcase
        end
    end
endmodule

// File: tb/tb_ddr_rw_wrr_arbiter.sv
// Directed bench for ddr_rw_wrr_arbiter: WRR pattern, read-only, write drain, stall and reset mid-turn.
// Inputs change on the falling edge. Outputs are checked 1 time unit later.
module tb_ddr_rw_wrr_arbiter;
    localparam logic [63:0] RdPay  = 64'hA5A5_0000_1111_0001;
    localparam logic [63:0] RdPay2 = 64'hBEEF_CAFE_0000_0002;
    localparam logic [63:0] WrPay  = 64'h5A5A_FFFF_2222_0003;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    ddr_rw_wrr_arbiter_if #(.PAYLOAD_W(64)) bus ();

    ddr_rw_wrr_arbiter #(
        .PAYLOAD_W (64),
        .RD_WEIGHT (8),
        .WR_WEIGHT (4),
        .TURN_RD2WR(4),
        .TURN_WR2RD(6),
        .WR_HI_WM  (24)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Holds reset over two rising edges and releases it on a falling edge.
    task automatic apply_reset(input logic rv, input logic wv, input logic [7:0] lvl);
        rst_n          = 1'b0;
        bus.rd_valid   = rv;
        bus.wr_valid   = wv;
        bus.wr_level   = lvl;
        bus.out_ready  = 1'b1;
        bus.rd_payload = RdPay;
        bus.wr_payload = WrPay;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [5:0] got;
        rst_n          = 1'b0;
        bus.rd_valid   = 1'b1;
        bus.wr_valid   = 1'b1;
        bus.wr_level   = 8'd0;
        bus.out_ready  = 1'b1;
        bus.rd_payload = RdPay;
        bus.wr_payload = WrPay;
        @(negedge clk);
        @(negedge clk);
        #1;
        got = {bus.out_valid, bus.out_is_wr, bus.rd_ready, bus.wr_ready, bus.mode_is_wr,
               bus.turnaround_active};
        n_checks++;
        if (got !== 6'b101000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected %b", got, 6'b101000);
        end
        n_checks++;
        if (bus.out_payload !== RdPay) begin
            n_fail++;
            $display("FAIL reset_payload: got %h expected %h", bus.out_payload, RdPay);
        end
        n_checks++;
        if ({bus.rd_wrr_credit, bus.wr_wrr_credit} !== {16'd8, 16'd4}) begin
            n_fail++;
            $display("FAIL reset_credits: got %0d/%0d expected 8/4", bus.rd_wrr_credit,
                     bus.wr_wrr_credit);
        end
    endtask

    // Both queues busy: 8 reads, 4 turn, 4 writes, 6 turn, repeating.
    task automatic test_pattern();
        logic [3:0] exp_f;
        logic [3:0] got_f;
        int         p;
        apply_reset(1'b1, 1'b1, 8'd0);
        for (int i = 0; i < 44; i++) begin
            #1;
            p = i % 22;
            exp_f[3] = (p < 8) || (p >= 12 && p < 16);
            exp_f[2] = (p >= 12 && p < 16);
            exp_f[1] = (p >= 8 && p < 12) || (p >= 16);
            exp_f[0] = (p >= 8 && p < 16);
            got_f = {bus.out_valid, bus.out_is_wr, bus.turnaround_active, bus.mode_is_wr};
            n_checks++;
            if (got_f !== exp_f) begin
                n_fail++;
                $display("FAIL pattern_flags cyc %0d: got %b expected %b", i, got_f, exp_f);
            end
            if (p < 8) begin
                n_checks++;
                if (bus.rd_wrr_credit !== 16'(8 - p) || bus.out_payload !== RdPay) begin
                    n_fail++;
                    $display("FAIL pattern_read cyc %0d: credit %0d payload %h expected %0d %h",
                             i, bus.rd_wrr_credit, bus.out_payload, 8 - p, RdPay);
                end
            end else if (p < 12) begin
                n_checks++;
                if (bus.rd_wrr_credit !== 16'd0) begin
                    n_fail++;
                    $display("FAIL pattern_rd_hold cyc %0d: got %0d expected 0", i,
                             bus.rd_wrr_credit);
                end
            end else if (p < 16) begin
                n_checks++;
                if (bus.wr_wrr_credit !== 16'(4 - (p - 12)) || bus.out_payload !== WrPay) begin
                    n_fail++;
                    $display("FAIL pattern_write cyc %0d: credit %0d payload %h expected %0d %h",
                             i, bus.wr_wrr_credit, bus.out_payload, 4 - (p - 12), WrPay);
                end
            end
            @(negedge clk);
        end
    endtask

    // Reads only: never turns, credit cycles 8..1 and reloads.
    task automatic test_rd_only();
        apply_reset(1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 20; i++) begin
            #1;
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_is_wr !== 1'b0 ||
                bus.turnaround_active !== 1'b0 || bus.rd_wrr_credit !== 16'(8 - (i % 8))) begin
                n_fail++;
                $display("FAIL rd_only cyc %0d: v=%b w=%b t=%b credit %0d expected 1 0 0 %0d",
                         i, bus.out_valid, bus.out_is_wr, bus.turnaround_active,
                         bus.rd_wrr_credit, 8 - (i % 8));
            end
            @(negedge clk);
        end
    endtask

    // High write level: a read and switch, then writes past credit zero until the level drops.
    task automatic test_drain();
        apply_reset(1'b1, 1'b0, 8'd30);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) bus.wr_valid = 1'b1;
            #1;
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_is_wr !== 1'b0 ||
                bus.rd_wrr_credit !== 16'(8 - i)) begin
                n_fail++;
                $display("FAIL drain_read cyc %0d: v=%b w=%b credit %0d expected 1 0 %0d", i,
                         bus.out_valid, bus.out_is_wr, bus.rd_wrr_credit, 8 - i);
            end
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (bus.turnaround_active !== 1'b1 || bus.out_valid !== 1'b0 ||
                bus.mode_is_wr !== 1'b1) begin
                n_fail++;
                $display("FAIL drain_turn cyc %0d: t=%b v=%b m=%b expected 1 0 1", i,
                         bus.turnaround_active, bus.out_valid, bus.mode_is_wr);
            end
            @(negedge clk);
        end
        for (int k = 0; k < 12; k++) begin
            if (k == 10) bus.wr_level = 8'd0;
            #1;
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_is_wr !== 1'b1 ||
                bus.wr_wrr_credit !== 16'(4 - (k % 4))) begin
                n_fail++;
                $display("FAIL drain_write k %0d: v=%b w=%b credit %0d expected 1 1 %0d", k,
                         bus.out_valid, bus.out_is_wr, bus.wr_wrr_credit, 4 - (k % 4));
            end
            @(negedge clk);
        end
        #1;
        n_checks++;
        if (bus.turnaround_active !== 1'b1 || bus.mode_is_wr !== 1'b0 ||
            bus.rd_wrr_credit !== 16'd5) begin
            n_fail++;
            $display("FAIL drain_exit: t=%b m=%b rd credit %0d expected 1 0 5",
                     bus.turnaround_active, bus.mode_is_wr, bus.rd_wrr_credit);
        end
    endtask

    // Back-pressure on the last read credit: the command is held and the switch waits.
    task automatic test_stall();
        apply_reset(1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 7; i++) @(negedge clk);
        bus.wr_valid   = 1'b1;
        bus.out_ready  = 1'b0;
        bus.rd_payload = RdPay2;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_payload !== RdPay2 || bus.rd_ready !== 1'b0 ||
                bus.turnaround_active !== 1'b0 || bus.rd_wrr_credit !== 16'd1) begin
                n_fail++;
                $display("FAIL stall_hold cyc %0d: v=%b pay %h r=%b t=%b credit %0d expected 1 %h 0 0 1",
                         i, bus.out_valid, bus.out_payload, bus.rd_ready,
                         bus.turnaround_active, bus.rd_wrr_credit, RdPay2);
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.rd_ready !== 1'b1 || bus.out_is_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release: v=%b r=%b w=%b expected 1 1 0", bus.out_valid,
                     bus.rd_ready, bus.out_is_wr);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (bus.turnaround_active !== 1'b1 || bus.mode_is_wr !== 1'b1 ||
            bus.rd_wrr_credit !== 16'd0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_switch: t=%b m=%b credit %0d v=%b expected 1 1 0 0",
                     bus.turnaround_active, bus.mode_is_wr, bus.rd_wrr_credit, bus.out_valid);
        end
    endtask

    // Reset in the second turn cycle abandons the turnaround.
    task automatic test_reset_mid_turn();
        apply_reset(1'b1, 1'b1, 8'd0);
        for (int i = 0; i < 9; i++) @(negedge clk);
        #1;
        n_checks++;
        if (bus.turnaround_active !== 1'b1) begin
            n_fail++;
            $display("FAIL midturn_pre: t=%b expected 1", bus.turnaround_active);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.turnaround_active !== 1'b0 || bus.mode_is_wr !== 1'b0 || bus.out_valid !== 1'b1 ||
            bus.rd_ready !== 1'b1 || bus.wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midturn_in_reset: t=%b m=%b v=%b r=%b w=%b expected 0 0 1 1 0",
                     bus.turnaround_active, bus.mode_is_wr, bus.out_valid, bus.rd_ready,
                     bus.wr_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (bus.turnaround_active !== 1'b0 || bus.mode_is_wr !== 1'b0 ||
            bus.out_is_wr !== 1'b0 || bus.rd_wrr_credit !== 16'd8 ||
            bus.wr_wrr_credit !== 16'd4) begin
            n_fail++;
            $display("FAIL midturn_after: t=%b m=%b w=%b credits %0d/%0d expected 0 0 0 8/4",
                     bus.turnaround_active, bus.mode_is_wr, bus.out_is_wr, bus.rd_wrr_credit,
                     bus.wr_wrr_credit);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (bus.rd_wrr_credit !== 16'd7 || bus.out_is_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL midturn_resume: credit %0d w=%b expected 7 0", bus.rd_wrr_credit,
                     bus.out_is_wr);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        test_reset();
        test_pattern();
        test_rd_only();
        test_drain();
        test_stall();
        test_reset_mid_turn();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
